sweep_controller: RTL and testbench

Sequences one light-seeking sweep for the sunflower tracker. On `start` it steps the servo position command through `NUM_POS` positions, waits a settle time at each, averages `SAMPLES` ADC readings, and records the position with the highest average. It then parks the servo at that position and publishes the result. It sits between the ADC capture register (upstream) and the servo PWM generator and HEX display path (downstream).

---
 rtl/sweep_if.sv | 26 ++
 rtl/sweep_controller.sv | 137 +++++++++++++
 tb/tb_sweep_controller.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sweep_if.sv
// Handshake bundle between the sweep controller, the ADC capture register
// and the servo/display path.
interface sweep_if #(
    parameter int NUM_POS = 16
) ();
    localparam int PW = $clog2(NUM_POS);

    logic          start;
    logic [11:0]   adc_value;
    logic          adc_valid;
    logic [PW-1:0] pos_out;
    logic          busy;
    logic          done;
    logic [PW-1:0] best_pos;
    logic [11:0]   best_value;

    modport master (
        output start, adc_value, adc_valid,
        input  pos_out, busy, done, best_pos, best_value
    );

    modport slave (
        input  start, adc_value, adc_valid,
        output pos_out, busy, done, best_pos, best_value
    );
endinterface

// File: rtl/sweep_controller.sv
// One light-seeking sweep: step the servo, settle, average ADC readings per
// position, then park on the brightest position and publish it.
//
// state   | meaning
// IDLE    | waiting for start, servo holds last position
// MOVE    | command servo to idx, load settle timer
// SETTLE  | wait for servo to settle, ADC ignored
// ACQ     | accumulate SAMPLES ADC strobes
// EVAL    | compare average against running best, advance idx
// PARK    | command servo to best position, load settle timer
// PSETTLE | wait for servo to settle at park position
// DONE    | publish result, pulse done
module sweep_controller #(
    parameter int NUM_POS       = 16,
    parameter int SETTLE_CYCLES = 1000000,
    parameter int SAMPLES       = 8
) (
    input logic   CLOCK_50,
    input logic   reset,
    sweep_if.slave bus
);
    localparam int PW = $clog2(NUM_POS);
    localparam int SL = $clog2(SAMPLES);
    localparam int AW = 12 + SL;
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int NW = SL + 1;

    typedef enum logic [2:0] {
        IDLE, MOVE, SETTLE, ACQ, EVAL, PARK, PSETTLE, DONE
    } state_t;

    state_t        state, next_state;
    logic [PW-1:0] idx, run_pos, pos_r, best_pos_r;
    logic [11:0]   run_val, best_val_r, avg;
    logic [AW-1:0] acc;
    logic [CW-1:0] settle_cnt;
    logic [NW-1:0] sample_cnt;
    logic          busy_r, done_r;
    logic          settle_last, sample_last, last_pos;

    assign settle_last = (settle_cnt == '0);
    assign sample_last = (sample_cnt == NW'(SAMPLES - 1));
    assign last_pos    = (idx == PW'(NUM_POS - 1));
    assign avg         = acc[AW-1:SL];

    assign bus.pos_out    = pos_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.best_pos   = best_pos_r;
    assign bus.best_value = best_val_r;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = MOVE;
            MOVE:    next_state = SETTLE;
            SETTLE:  if (settle_last) next_state = ACQ;
            ACQ:     if (bus.adc_valid && sample_last) next_state = EVAL;
            EVAL:    next_state = last_pos ? PARK : MOVE;
            PARK:    next_state = PSETTLE;
            PSETTLE: if (settle_last) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            run_pos    <= '0;
            run_val    <= '0;
            acc        <= '0;
            settle_cnt <= '0;
            sample_cnt <= '0;
            pos_r      <= '0;
            best_pos_r <= '0;
            best_val_r <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            // busy/done are registered copies of the next state
            busy_r <= (next_state != IDLE);
            done_r <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        idx        <= '0;
                        run_pos    <= '0;
                        run_val    <= '0;
                        acc        <= '0;
                        sample_cnt <= '0;
                    end
                end
                MOVE: begin
                    pos_r      <= idx;
                    settle_cnt <= CW'(SETTLE_CYCLES - 1);
                end
                SETTLE: begin
                    if (!settle_last) settle_cnt <= settle_cnt - CW'(1);
                end
                ACQ: begin
                    if (bus.adc_valid) begin
                        acc        <= acc + AW'(bus.adc_value);
                        sample_cnt <= sample_last ? '0 : sample_cnt + NW'(1);
                    end
                end
                EVAL: begin
                    // strict compare so ties keep the earlier position
                    if (avg > run_val) begin
                        run_val <= avg;
                        run_pos <= idx;
                    end
                    acc <= '0;
                    if (!last_pos) idx <= idx + PW'(1);
                end
                PARK: begin
                    pos_r      <= run_pos;
                    settle_cnt <= CW'(SETTLE_CYCLES - 1);
                end
                PSETTLE: begin
                    if (settle_last) begin
                        best_pos_r <= run_pos;
                        best_val_r <= run_val;
                    end else begin
                        settle_cnt <= settle_cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sweep_controller.sv
// Bench for sweep_controller with NUM_POS=4, SETTLE_CYCLES=3, SAMPLES=2.
module tb_sweep_controller;
    localparam int NP = 4;
    localparam int SC = 3;
    localparam int NS = 2;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    always #10 CLOCK_50 = ~CLOCK_50;

    sweep_if #(.NUM_POS(NP)) bus ();

    sweep_controller #(
        .NUM_POS(NP), .SETTLE_CYCLES(SC), .SAMPLES(NS)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .bus     (bus)
    );

    typedef struct packed {
        logic [NP-1:0][11:0] a;
        logic [NP-1:0][11:0] b;
        logic [1:0]          pos;
        logic [11:0]         val;
        logic                junk;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int done_seen = 0;
    int prev_pos = 0;
    int prev_val = 0;

    always @(negedge CLOCK_50) if (!reset && bus.done === 1'b1) done_seen++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    function automatic vec_t mkvec(input int a0, b0, a1, b1, a2, b2, a3, b3,
                                   input int pos, val, input bit junk);
        vec_t v;
        v.a    = {12'(a3), 12'(a2), 12'(a1), 12'(a0)};
        v.b    = {12'(b3), 12'(b2), 12'(b1), 12'(b0)};
        v.pos  = 2'(pos);
        v.val  = 12'(val);
        v.junk = junk;
        return v;
    endfunction

    // Reference: brightest truncated mean, first position wins a tie
    function automatic vec_t ref_model(input vec_t v);
        vec_t r = v;
        int best_v = 0;
        int best_p = 0;
        for (int i = 0; i < NP; i++) begin
            int m = (int'(v.a[i]) + int'(v.b[i])) / NS;
            if (m > best_v) begin
                best_v = m;
                best_p = i;
            end
        end
        r.pos = 2'(best_p);
        r.val = 12'(best_v);
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        int hi = ($urandom_range(0, 1) == 0) ? 3 : 4095;
        for (int i = 0; i < NP; i++) begin
            v.a[i] = 12'($urandom_range(0, hi));
            v.b[i] = 12'($urandom_range(0, hi));
        end
        v.junk = 1'($urandom_range(0, 1));
        return ref_model(v);
    endfunction

    // Entered in the MOVE cycle; returns in the DONE cycle, or right after
    // a reset when abort_at names a position.
    task automatic sweep_body(input vec_t v, input bit poke_start, input int abort_at,
                              output bit aborted);
        aborted = 1'b0;
        for (int p = 0; p < NP; p++) begin
            check("busy_in_sweep", 32'(bus.busy), 1);
            tick();
            check("pos_step", 32'(bus.pos_out), p);
            if (v.junk) begin
                bus.adc_valid = 1'b1;
                bus.adc_value = 12'd4095;
            end
            if (poke_start && p == 1) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            tick();
            tick();
            bus.adc_valid = 1'b0;
            if (abort_at == p) begin
                tick();
                reset = 1'b1;
                #1;
                check("abort_pos", 32'(bus.pos_out), 0);
                check("abort_busy", 32'(bus.busy), 0);
                check("abort_best_pos", 32'(bus.best_pos), 0);
                check("abort_best_val", 32'(bus.best_value), 0);
                tick();
                reset = 1'b0;
                prev_pos = 0;
                prev_val = 0;
                aborted = 1'b1;
                return;
            end
            repeat ($urandom_range(0, 2)) tick();
            bus.adc_valid = 1'b1;
            bus.adc_value = v.a[p];
            tick();
            bus.adc_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
            bus.adc_valid = 1'b1;
            bus.adc_value = v.b[p];
            tick();
            bus.adc_valid = 1'b0;
            tick();
        end
        check("hold_best_pos", 32'(bus.best_pos), prev_pos);
        check("hold_best_val", 32'(bus.best_value), prev_val);
        tick();
        check("park_pos", 32'(bus.pos_out), 32'(v.pos));
        tick();
        tick();
        check("no_early_done", 32'(bus.done), 0);
        tick();
        check("done_pulse", 32'(bus.done), 1);
        check("best_pos", 32'(bus.best_pos), 32'(v.pos));
        check("best_value", 32'(bus.best_value), 32'(v.val));
        prev_pos = int'(v.pos);
        prev_val = int'(v.val);
    endtask

    task automatic full_sweep(input vec_t v, input bit poke_start);
        int d0 = done_seen;
        bit ab;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 1);
        sweep_body(v, poke_start, -1, ab);
        tick();
        check("idle_busy", 32'(bus.busy), 0);
        check("idle_done", 32'(bus.done), 0);
        check("idle_pos_hold", 32'(bus.pos_out), 32'(v.pos));
        check("done_count", done_seen, d0 + 1);
    endtask

    vec_t table_v[3];

    initial begin
        vec_t v, v2;
        bit   ab;
        int   d0;

        table_v[0] = mkvec(100, 102, 500, 502, 300, 300, 50, 51, 1, 501, 1'b0);
        table_v[1] = mkvec(7, 8, 6, 9, 8, 7, 0, 0, 0, 7, 1'b0);
        table_v[2] = mkvec(10, 10, 10, 10, 10, 10, 10, 10, 0, 10, 1'b1);

        bus.start     = 1'b0;
        bus.adc_valid = 1'b0;
        bus.adc_value = '0;
        tick();
        tick();
        check("rst_pos", 32'(bus.pos_out), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_best_pos", 32'(bus.best_pos), 0);
        check("rst_best_val", 32'(bus.best_value), 0);
        reset = 1'b0;
        tick();

        // no strobes: sweep must stall in the first acquisition
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (40) tick();
        check("stall_busy", 32'(bus.busy), 1);
        check("stall_pos", 32'(bus.pos_out), 0);
        check("stall_no_done", done_seen, 0);
        reset = 1'b1;
        #1;
        check("stall_reset_busy", 32'(bus.busy), 0);
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 3; i++) full_sweep(table_v[i], 1'b0);

        // start while busy: ignored and not queued
        v = rand_vec();
        full_sweep(v, 1'b1);
        repeat (5) tick();
        check("start_not_queued", 32'(bus.busy), 0);

        // start held across DONE launches the next sweep from first IDLE cycle
        v  = table_v[0];
        v2 = table_v[1];
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        sweep_body(v, 1'b0, -1, ab);
        bus.start = 1'b1;
        tick();
        check("chain_idle_busy", 32'(bus.busy), 0);
        tick();
        check("chain_move_busy", 32'(bus.busy), 1);
        bus.start = 1'b0;
        sweep_body(v2, 1'b0, -1, ab);
        tick();
        check("chain_end_busy", 32'(bus.busy), 0);

        // reset during position 2 acquisition
        d0 = done_seen;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        sweep_body(table_v[0], 1'b0, 2, ab);
        check("abort_taken", 32'(ab), 1);
        repeat (3) tick();
        check("abort_no_done", done_seen, d0);
        full_sweep(table_v[0], 1'b0);

        for (int i = 0; i < 8; i++) full_sweep(rand_vec(), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
